// File: rtl/pkt_repeat.sv
// pkt_repeat: buffers one input packet and replays it RPT times (1:N packet
// rate expansion). The header presented with the first input beat is reused
// for every repetition. A two-entry output stage (RAM output register plus one
// skid entry) keeps one word per cycle under back-pressure.
module pkt_repeat #(
    parameter int WIDTH             = 32,
    parameter int MAX_PKT_SIZE_LOG2 = 14,
    parameter int MAX_RPT_SIZE_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      i_tdata,
    input  logic [127:0]          i_tuser,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic [127:0]          o_tuser,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    input  logic [23:0]           i_config_tdata,
    input  logic                  i_config_tvalid,
    output logic                  i_config_tready,
    output logic                  o_trunc
);

    localparam int AW    = MAX_PKT_SIZE_LOG2;
    localparam int RW    = MAX_RPT_SIZE_LOG2;
    localparam int DEPTH = 2 ** AW;

    localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
    localparam logic [AW-1:0] ADDR_MAX    = '1;
    localparam logic [AW:0]   LEN_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   LEN_MAX     = {1'b1, {AW{1'b0}}};
    localparam logic [RW-1:0] RPT_ONE     = RW'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_REPLAY
    } state_t;

    state_t state, state_nxt;

    // packet buffer
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] q_data;

    // write side / packet description
    logic [AW-1:0]    wr_addr;
    logic [AW:0]      len;
    logic [127:0]     hdr;
    logic [RW-1:0]    rpt;
    logic [RW-1:0]    rep_cnt;

    // read issue side
    logic [AW-1:0]    rd_addr;
    logic [RW-1:0]    rd_rep;
    logic             rd_done;
    logic             rd_en;
    logic             rd_last;

    // output stage: RAM output register (q) and skid entry (sk), sk is older
    logic             q_vld;
    logic             q_last;
    logic             sk_vld;
    logic             sk_last;
    logic [WIDTH-1:0] sk_data;

    logic             in_hs;
    logic             out_hs;
    logic             cfg_hs;
    logic [RW-1:0]    cfg_rpt;
    logic [23-RW:0]   unused_cfg_bits;

    assign in_hs           = i_tvalid && i_tready;
    assign out_hs          = o_tvalid && o_tready;
    assign cfg_hs          = i_config_tvalid && i_config_tready;
    assign cfg_rpt         = i_config_tdata[RW-1:0];
    assign unused_cfg_bits = i_config_tdata[23:RW];
    assign rd_last         = ({1'b0, rd_addr} == (len - LEN_ONE));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: fill until tlast (or overflow into drain), replay until the
    // final tlast of the final repetition is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (in_hs) begin
                    if (i_tlast) begin
                        state_nxt = S_REPLAY;
                    end else if (wr_addr == ADDR_MAX) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (in_hs && i_tlast) begin
                    state_nxt = S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (out_hs && o_tlast && (rep_cnt == (rpt - RPT_ONE))) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // handshake outputs and read issue; the output head is the skid entry
    // when occupied, otherwise the RAM output register
    always_comb begin
        i_tready        = !reset && ((state == S_FILL) || (state == S_DRAIN));
        i_config_tready = !reset && (state == S_FILL) && (wr_addr == '0);
        // a new read is only issued while the skid is empty, so a stalled
        // head can always be parked there without losing the RAM word
        rd_en           = (state == S_REPLAY) && !rd_done && !sk_vld;
        o_tvalid        = sk_vld || q_vld;
        o_tuser         = hdr;
        if (sk_vld) begin
            o_tdata = sk_data;
            o_tlast = sk_last;
        end else if (q_vld) begin
            o_tdata = q_data;
            o_tlast = q_last;
        end else begin
            o_tdata = '0;
            o_tlast = 1'b0;
        end
    end

    // packet RAM: write during fill, registered read during replay
    always_ff @(posedge clk) begin
        if (in_hs && (state == S_FILL)) begin
            mem[wr_addr] <= i_tdata;
        end
        if (rd_en) begin
            q_data <= mem[rd_addr];
        end
    end

    // fill bookkeeping, configuration and truncation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            len     <= '0;
            hdr     <= '0;
            rpt     <= RPT_ONE;
            o_trunc <= 1'b0;
        end else begin
            if (cfg_hs) begin
                rpt <= (cfg_rpt == '0) ? RPT_ONE : cfg_rpt;
            end
            if (in_hs && (state == S_FILL)) begin
                if (wr_addr == '0) begin
                    hdr <= i_tuser;
                end
                if (i_tlast) begin
                    len     <= {1'b0, wr_addr} + LEN_ONE;
                    wr_addr <= '0;
                end else if (wr_addr == ADDR_MAX) begin
                    len     <= LEN_MAX;
                    o_trunc <= 1'b1;
                    wr_addr <= '0;
                end else begin
                    wr_addr <= wr_addr + ADDR_ONE;
                end
            end
        end
    end

    // read address / repetition issue counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            rd_rep  <= '0;
            rd_done <= 1'b0;
        end else if (state != S_REPLAY) begin
            rd_addr <= '0;
            rd_rep  <= '0;
            rd_done <= 1'b0;
        end else if (rd_en) begin
            if (rd_last) begin
                rd_addr <= '0;
                if (rd_rep == (rpt - RPT_ONE)) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_rep <= rd_rep + RPT_ONE;
                end
            end else begin
                rd_addr <= rd_addr + ADDR_ONE;
            end
        end
    end

    // output stage occupancy and skid capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_vld   <= 1'b0;
            q_last  <= 1'b0;
            sk_vld  <= 1'b0;
            sk_last <= 1'b0;
            sk_data <= '0;
        end else if (sk_vld) begin
            if (out_hs) begin
                sk_vld <= 1'b0;
            end
        end else if (rd_en) begin
            q_vld  <= 1'b1;
            q_last <= rd_last;
            if (q_vld && !out_hs) begin
                sk_vld  <= 1'b1;
                sk_data <= q_data;
                sk_last <= q_last;
            end
        end else if (out_hs) begin
            q_vld <= 1'b0;
        end
    end

    // completed-repetition counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (out_hs && o_tlast) begin
            if (rep_cnt == (rpt - RPT_ONE)) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + RPT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pkt_repeat.sv
// tb_pkt_repeat: directed checks of pkt_repeat replay, config, truncation and reset.
module tb_pkt_repeat;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  i_tdata = '0;
    logic [127:0]  i_tuser = '0;
    logic          i_tlast = 1'b0;
    logic          i_tvalid = 1'b0;
    logic          i_tready;
    logic [W-1:0]  o_tdata;
    logic [127:0]  o_tuser;
    logic          o_tlast;
    logic          o_tvalid;
    logic          o_tready = 1'b0;
    logic [23:0]   i_config_tdata = '0;
    logic          i_config_tvalid = 1'b0;
    logic          i_config_tready;
    logic          o_trunc;

    pkt_repeat #(
        .WIDTH(W),
        .MAX_PKT_SIZE_LOG2(14),
        .MAX_RPT_SIZE_LOG2(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_tdata(i_tdata),
        .i_tuser(i_tuser),
        .i_tlast(i_tlast),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .o_tdata(o_tdata),
        .o_tuser(o_tuser),
        .o_tlast(o_tlast),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready),
        .i_config_tdata(i_config_tdata),
        .i_config_tvalid(i_config_tvalid),
        .i_config_tready(i_config_tready),
        .o_trunc(o_trunc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tl_cyc = 0;
    int ov_cyc = -1;
    int arm = 0;
    int cfg_hs_cyc = 0;
    int last_out_cyc = 0;
    int irdy_viol = 0;
    int crdy_viol = 0;
    int hold_err = 0;
    int otr_mode = 0;
    logic pending = 1'b0;

    logic [W-1:0]  rx_d[$];
    logic          rx_l[$];
    logic [127:0]  rx_u[$];
    logic [W-1:0]  ex_d[$];
    logic          ex_l[$];
    logic [127:0]  ex_u[$];

    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_d = '0;
    logic          prev_l = 1'b0;
    logic [127:0]  prev_u = '0;

    localparam logic [127:0] H1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] H2 = 128'hA5A5_0000_FFFF_1234_0F0F_F0F0_DEAD_BEEF;
    localparam logic [127:0] H3 = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    localparam logic [127:0] H4 = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0246_8ACE;
    localparam logic [127:0] H5 = 128'h5555_AAAA_5555_AAAA_1357_9BDF_2468_ACE0;
    localparam logic [127:0] H6 = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
    localparam logic [127:0] H7 = 128'h7777_1111_7777_1111_7777_1111_7777_1111;
    localparam logic [127:0] H8 = 128'h8888_2222_8888_2222_8888_2222_8888_2222;
    localparam logic [127:0] H9 = 128'h9999_3333_9999_3333_9999_3333_9999_3333;

    // output ready pattern: 0 = always ready, 1 = random 50%
    always @(posedge clk) begin
        #1;
        o_tready = (otr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // monitor: sample everything mid-cycle, collect accepted output beats
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(o_tvalid && o_tdata == prev_d && o_tlast == prev_l && o_tuser == prev_u))
                hold_err++;
            prev_stall = o_tvalid && !o_tready;
            prev_d = o_tdata;
            prev_l = o_tlast;
            prev_u = o_tuser;
            if (i_tvalid && i_tready && i_tlast) tl_cyc = cyc;
            if (arm != 0 && o_tvalid && ov_cyc < 0) ov_cyc = cyc;
            pending = ex_d.size() > rx_d.size();
            if (pending && i_tready) irdy_viol++;
            if (pending && i_config_tready) crdy_viol++;
            if (i_config_tvalid && i_config_tready) cfg_hs_cyc = cyc;
            if (o_tvalid && o_tready) begin
                rx_d.push_back(o_tdata);
                rx_l.push_back(o_tlast);
                rx_u.push_back(o_tuser);
                if (o_tlast) last_out_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rx_d.delete(); rx_l.delete(); rx_u.delete();
        ex_d.delete(); ex_l.delete(); ex_u.delete();
        ov_cyc = -1;
        arm = 0;
        irdy_viol = 0;
        crdy_viol = 0;
        hold_err = 0;
    endtask

    task automatic cfg(input int v);
        logic hs;
        int t;
        hs = 1'b0;
        t = 0;
        i_config_tvalid = 1'b1;
        i_config_tdata = 24'(v);
        while (!hs && t < 50000) begin
            hs = i_config_tready;
            tick();
            t++;
        end
        i_config_tvalid = 1'b0;
        i_config_tdata = '0;
        if (!hs) check("cfg handshake timeout", 0, 1);
    endtask

    task automatic send_pkt(input int n, input int base, input logic [127:0] hdr);
        logic hs;
        int t;
        for (int i = 0; i < n; i++) begin
            i_tvalid = 1'b1;
            i_tdata = W'(base + i);
            i_tuser = (i == 0) ? hdr : ~hdr;
            i_tlast = (i == n - 1);
            hs = 1'b0;
            t = 0;
            while (!hs && t < 1000) begin
                hs = i_tready;
                tick();
                t++;
            end
            if (!hs) begin
                check("send handshake timeout", 0, 1);
                break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
    endtask

    task automatic expect_pkt(input int n, input int base, input logic [127:0] hdr, input int copies);
        for (int c = 0; c < copies; c++) begin
            for (int i = 0; i < n; i++) begin
                ex_d.push_back(W'(base + i));
                ex_l.push_back(i == n - 1);
                ex_u.push_back(hdr);
            end
        end
    endtask

    task automatic wait_out(input int budget);
        int t;
        t = 0;
        while (rx_d.size() < ex_d.size() && t < budget) begin
            tick();
            t++;
        end
        repeat (6) tick();
    endtask

    task automatic verify(input string tag);
        int err;
        int n;
        err = 0;
        n = (rx_d.size() < ex_d.size()) ? rx_d.size() : ex_d.size();
        check({tag, " beat count"}, rx_d.size(), ex_d.size());
        for (int i = 0; i < n; i++) begin
            if (rx_d[i] !== ex_d[i] || rx_l[i] !== ex_l[i] || rx_u[i] !== ex_u[i]) err++;
        end
        check({tag, " beat mismatches"}, err, 0);
    endtask

    initial begin
        // reset values
        repeat (3) tick();
        check("rst o_tvalid", o_tvalid, 0);
        check("rst o_tlast", o_tlast, 0);
        check("rst o_tdata", o_tdata, 0);
        check("rst o_tuser", o_tuser, 0);
        check("rst i_tready", i_tready, 0);
        check("rst i_config_tready", i_config_tready, 0);
        check("rst o_trunc", o_trunc, 0);
        reset = 1'b0;
        tick();
        check("idle i_tready", i_tready, 1);
        check("idle i_config_tready", i_config_tready, 1);

        // 1: RPT=3, 8-word packet
        clear();
        cfg(3);
        arm = 1;
        send_pkt(8, 0, H1);
        expect_pkt(8, 0, H1, 3);
        wait_out(2000);
        verify("t1");
        check("t1 latency", ov_cyc - tl_cyc, 2);
        check("t1 tlast word7", rx_l[7], 1);
        check("t1 tlast word6", rx_l[6], 0);
        check("t1 data word8", rx_d[8], 0);
        check("t1 tuser word23", rx_u[23], H1);
        check("t1 i_tready during replay", irdy_viol, 0);
        check("t1 o_trunc", o_trunc, 0);

        // 2: RPT=0 behaves as 1
        clear();
        cfg(0);
        send_pkt(4, 100, H2);
        expect_pkt(4, 100, H2, 1);
        wait_out(1000);
        verify("t2");
        check("t2 tlast word3", rx_l[3], 1);
        check("t2 i_tready back", i_tready, 1);

        // 3: RPT=2, 16 words, random back-pressure
        clear();
        cfg(2);
        otr_mode = 1;
        send_pkt(16, 200, H3);
        expect_pkt(16, 200, H3, 2);
        wait_out(5000);
        otr_mode = 0;
        verify("t3");
        check("t3 i_tready during replay", irdy_viol, 0);
        check("t3 hold under stall", hold_err, 0);

        // 4: oversize packet truncated to 16384 words
        clear();
        cfg(1);
        send_pkt(16384 + 5, 0, H4);
        expect_pkt(16384, 0, H4, 1);
        wait_out(40000);
        verify("t4");
        check("t4 o_trunc", o_trunc, 1);
        check("t4 final word data", rx_d[16383], 16383);
        check("t4 final word tlast", rx_l[16383], 1);
        clear();
        send_pkt(4, 500, H5);
        expect_pkt(4, 500, H5, 1);
        wait_out(1000);
        verify("t4b");
        check("t4b o_trunc sticky", o_trunc, 1);

        // 5: reset during second repetition of RPT=4
        clear();
        cfg(4);
        send_pkt(3, 600, H6);
        begin
            int t;
            t = 0;
            while (rx_d.size() < 4 && t < 500) begin
                tick();
                t++;
            end
        end
        check("t5 reached rep2", rx_d.size() >= 4, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5 o_tvalid in reset", o_tvalid, 0);
        check("t5 i_tready in reset", i_tready, 0);
        tick();
        tick();
        reset = 1'b0;
        clear();
        tick();
        check("t5 o_trunc cleared", o_trunc, 0);
        send_pkt(1, 700, H7);
        expect_pkt(1, 700, H7, 1);
        wait_out(500);
        repeat (10) tick();
        verify("t5");
        check("t5 single beat tlast", rx_l[0], 1);

        // 6: config offered during replay waits for FILL, applies to next packet
        clear();
        cfg(2);
        send_pkt(3, 800, H8);
        expect_pkt(3, 800, H8, 2);
        check("t6 config blocked in replay", i_config_tready, 0);
        cfg(3);
        check("t6 config after replay", cfg_hs_cyc > last_out_cyc, 1);
        check("t6 config ready during replay", crdy_viol, 0);
        wait_out(500);
        verify("t6a");
        clear();
        send_pkt(2, 900, H9);
        expect_pkt(2, 900, H9, 3);
        wait_out(1000);
        verify("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
